mem_stage: RTL and testbench

//  MEM stage of the 5-stage RV32I pipeline: sits between ex_mem_regs and mem_wb_regs.

---
 rtl/mem_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RV32I pipeline (between ex_mem_regs and mem_wb_regs).
// Issues data-memory requests and holds each one until dmem_resp. Formats load
// data and store data/byte enables, and stalls the pipeline while an access is
// outstanding.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   valid_i, mem_read_i,     EX/MEM slot contents: valid flag, load/store flags,
//   mem_write_i, funct3_i,   width/sign encoding, byte address, store data
//   alu_out_i, rs2_data_i
//   advance_i                whole pipeline advances this cycle
//   dmem_rdata, dmem_resp    memory read data and completion strobe
//   dmem_read, dmem_write,   memory request, word address, lane-replicated
//   dmem_address,            store data, byte enables
//   dmem_wdata, dmem_mbe
//   mem_data_out_o           formatted load data (0 for non-loads)
//   stall_o                  MEM stage not finished this cycle
//   misaligned_o             misaligned access; no request issued
//   mem_stall_cycles_o       saturating count of stalled cycles
module mem_stage #(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic [2:0]             funct3_i,
    input  logic [31:0]            alu_out_i,
    input  logic [31:0]            rs2_data_i,
    input  logic                   advance_i,
    input  logic [31:0]            dmem_rdata,
    input  logic                   dmem_resp,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [31:0]            dmem_address,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_mbe,
    output logic [31:0]            mem_data_out_o,
    output logic                   stall_o,
    output logic                   misaligned_o,
    output logic [STALL_CNT_W-1:0] mem_stall_cycles_o
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            held_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [1:0]  lane;
    logic [31:0] byte_shift, half_shift, fmt_data;
    logic [3:0]  store_mbe;
    logic [31:0] store_wdata;
    logic        acc, req;

    assign lane = alu_out_i[1:0];

    // Alignment check and access qualification
    always_comb begin
        misaligned_o = 1'b0;
        if (valid_i && (mem_read_i || mem_write_i)) begin
            if (funct3_i == 3'b001 || (funct3_i == 3'b101 && mem_read_i))
                misaligned_o = alu_out_i[0];
            else if (funct3_i == 3'b010)
                misaligned_o = (lane != 2'b00);
        end
        acc = valid_i && (mem_read_i || mem_write_i) && !misaligned_o;
    end

    // Load data formatting from the addressed byte lane / half
    always_comb begin
        byte_shift = dmem_rdata >> {lane, 3'b000};
        half_shift = dmem_rdata >> {alu_out_i[1], 4'b0000};
        case (funct3_i)
            3'b000:  fmt_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b100:  fmt_data = {24'h000000, byte_shift[7:0]};
            3'b001:  fmt_data = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b101:  fmt_data = {16'h0000, half_shift[15:0]};
            3'b010:  fmt_data = dmem_rdata;
            default: fmt_data = 32'h0;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        store_mbe   = 4'b0000;
        store_wdata = 32'h0;
        case (funct3_i)
            3'b000: begin
                store_mbe   = 4'b0001 << lane;
                store_wdata = {4{rs2_data_i[7:0]}};
            end
            3'b001: begin
                store_mbe   = 4'b0011 << lane;
                store_wdata = {2{rs2_data_i[15:0]}};
            end
            3'b010: begin
                store_mbe   = 4'hF;
                store_wdata = rs2_data_i;
            end
            default: ;
        endcase
    end

    // State register, held load data and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            held_q      <= 32'h0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (req && dmem_resp)
                held_q <= mem_read_i ? fmt_data : 32'h0;
            if (stall_o && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Next state and request outputs; HOLD keeps a completed access from re-issuing
    always_comb begin
        state_d        = state_q;
        req            = 1'b0;
        dmem_read      = 1'b0;
        dmem_write     = 1'b0;
        dmem_mbe       = 4'b0000;
        dmem_wdata     = 32'h0;
        stall_o        = 1'b0;
        mem_data_out_o = (valid_i && mem_read_i) ? fmt_data : 32'h0;
        case (state_q)
            IDLE: begin
                req = acc;
                if (acc)
                    state_d = dmem_resp ? (advance_i ? IDLE : HOLD) : BUSY;
            end
            BUSY: begin
                req = 1'b1;
                if (dmem_resp)
                    state_d = advance_i ? IDLE : HOLD;
            end
            HOLD: begin
                mem_data_out_o = held_q;
                if (advance_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (req) begin
            dmem_read  = mem_read_i;
            dmem_write = mem_write_i;
            dmem_mbe   = mem_read_i ? 4'hF : store_mbe;
            dmem_wdata = mem_write_i ? store_wdata : 32'h0;
            stall_o    = !dmem_resp;
        end
    end

    assign dmem_address       = {alu_out_i[31:2], 2'b00};
    assign mem_stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed and randomized load/store transactions
// checked against a transaction-level reference model.
module tb_mem_stage;

    logic        clk, rst;
    logic        valid_i, mem_read_i, mem_write_i, advance_i, dmem_resp;
    logic [2:0]  funct3_i;
    logic [31:0] alu_out_i, rs2_data_i, dmem_rdata;
    logic        dmem_read, dmem_write, stall_o, misaligned_o;
    logic [31:0] dmem_address, dmem_wdata, mem_data_out_o;
    logic [3:0]  dmem_mbe;
    logic [31:0] mem_stall_cycles_o;

    int checks = 0;
    int errors = 0;
    int unsigned exp_cnt = 0;

    mem_stage #(.STALL_CNT_W(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .funct3_i(funct3_i), .alu_out_i(alu_out_i),
        .rs2_data_i(rs2_data_i), .advance_i(advance_i), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
        .mem_data_out_o(mem_data_out_o), .stall_o(stall_o),
        .misaligned_o(misaligned_o), .mem_stall_cycles_o(mem_stall_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
        logic [31:0] byt, half;
        byt  = (d >> (8 * (a % 4))) & 32'hFF;
        half = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (byt >= 128) ? (byt | 32'hFFFFFF00) : byt;
            3'd4:    return byt;
            3'd1:    return (half >= 32768) ? (half | 32'hFFFF0000) : half;
            3'd5:    return half;
            3'd2:    return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_misaligned(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if (f3 == 3'd1 || (f3 == 3'd5 && rd)) return (a % 2) != 0;
        if (f3 == 3'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_mbe(input logic rd, input logic [2:0] f3,
                                         input logic [31:0] a);
        if (rd) return 4'hF;
        case (f3)
            3'd0:    return 4'(1 << (a % 4));
            3'd1:    return 4'(3 << (a % 4));
            3'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] r);
        case (f3)
            3'd0:    return (r & 32'hFF) * 32'h01010101;
            3'd1:    return (r & 32'hFFFF) * 32'h00010001;
            3'd2:    return r;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0; mem_read_i = 0; mem_write_i = 0; funct3_i = 0;
        alu_out_i = 0; rs2_data_i = 0; advance_i = 1; dmem_rdata = 0; dmem_resp = 0;
    endtask

    // One instruction through MEM: wait_n stall cycles, then completion, then
    // hold_n cycles in HOLD (the last of which advances).
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] r,
                             input logic [31:0] rdata, input int wait_n, input int hold_n);
        logic        mis;
        logic [31:0] exp_data;
        mis      = m_misaligned(rd, wr, f3, a);
        exp_data = rd ? m_load(f3, a, rdata) : 32'h0;
        valid_i = 1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
        alu_out_i = a; rs2_data_i = r; dmem_resp = 0; dmem_rdata = $urandom;
        if (mis || !(rd || wr)) begin
            advance_i = 1;
            @(negedge clk);
            checks++;
            if (misaligned_o !== mis || dmem_read !== 0 || dmem_write !== 0 || stall_o !== 0) begin
                errors++;
                $display("FAIL noreq a=%h f3=%0d: mis=%b rd=%b wr=%b stall=%b, want mis=%b 0 0 0",
                         a, f3, misaligned_o, dmem_read, dmem_write, stall_o, mis);
            end
            if (!rd) begin
                checks++;
                if (mem_data_out_o !== 32'h0) begin
                    errors++;
                    $display("FAIL nonload_data: got %h want 0", mem_data_out_o);
                end
            end
            step();
            idle_inputs();
            return;
        end
        advance_i = 0;
        for (int k = 0; k < wait_n; k++) begin
            @(negedge clk);
            checks++;
            if (dmem_read !== rd || dmem_write !== wr || stall_o !== 1 || misaligned_o !== 0 ||
                dmem_address !== (a & 32'hFFFFFFFC) || dmem_mbe !== m_mbe(rd, f3, a) ||
                (wr && dmem_wdata !== m_wdata(f3, r))) begin
                errors++;
                $display("FAIL wait a=%h: rd=%b wr=%b stall=%b addr=%h mbe=%h wd=%h want %b %b 1 %h %h %h",
                         a, dmem_read, dmem_write, stall_o, dmem_address, dmem_mbe, dmem_wdata,
                         rd, wr, a & 32'hFFFFFFFC, m_mbe(rd, f3, a), m_wdata(f3, r));
            end
            exp_cnt += 1;
            step();
        end
        dmem_resp = 1; dmem_rdata = rdata; advance_i = (hold_n == 0);
        @(negedge clk);
        checks++;
        if (dmem_read !== rd || dmem_write !== wr || stall_o !== 0 ||
            dmem_address !== (a & 32'hFFFFFFFC) || dmem_mbe !== m_mbe(rd, f3, a) ||
            (wr && dmem_wdata !== m_wdata(f3, r)) || mem_data_out_o !== exp_data) begin
            errors++;
            $display("FAIL complete a=%h f3=%0d: rd=%b wr=%b stall=%b addr=%h mbe=%h wd=%h data=%h want %b %b 0 %h %h %h %h",
                     a, f3, dmem_read, dmem_write, stall_o, dmem_address, dmem_mbe, dmem_wdata,
                     mem_data_out_o, rd, wr, a & 32'hFFFFFFFC, m_mbe(rd, f3, a),
                     m_wdata(f3, r), exp_data);
        end
        checks++;
        if (mem_stall_cycles_o !== exp_cnt) begin
            errors++;
            $display("FAIL stall_count: got %0d want %0d", mem_stall_cycles_o, exp_cnt);
        end
        step();
        for (int h = 0; h < hold_n; h++) begin
            advance_i  = (h == hold_n - 1);
            dmem_resp  = 1'($urandom);
            dmem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (dmem_read !== 0 || dmem_write !== 0 || stall_o !== 0 || mem_data_out_o !== exp_data) begin
                errors++;
                $display("FAIL hold a=%h: rd=%b wr=%b stall=%b data=%h want 0 0 0 %h",
                         a, dmem_read, dmem_write, stall_o, mem_data_out_o, exp_data);
            end
            step();
        end
        idle_inputs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step(); step();
        @(negedge clk);
        checks++;
        if (dmem_read !== 0 || dmem_write !== 0 || stall_o !== 0 || misaligned_o !== 0 ||
            mem_data_out_o !== 0 || dmem_mbe !== 0 || dmem_wdata !== 0 || mem_stall_cycles_o !== 0) begin
            errors++;
            $display("FAIL reset_state: rd=%b wr=%b stall=%b mis=%b data=%h mbe=%h wd=%h cnt=%0d want all 0",
                     dmem_read, dmem_write, stall_o, misaligned_o, mem_data_out_o, dmem_mbe,
                     dmem_wdata, mem_stall_cycles_o);
        end
        rst = 0;
        step();
        exp_cnt = 0;
    endtask

    task automatic test_directed_loads();
        do_access(1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 3, 0);
        do_access(1, 0, 3'd0, 32'h103, 0, 32'h80112233, 1, 0);
        do_access(1, 0, 3'd4, 32'h103, 0, 32'h80112233, 0, 0);
        do_access(1, 0, 3'd5, 32'h102, 0, 32'h80112233, 2, 0);
        do_access(1, 0, 3'd3, 32'h108, 0, 32'h12345678, 0, 0);
    endtask

    task automatic test_directed_stores();
        do_access(0, 1, 3'd0, 32'h201, 32'h000000AB, 0, 1, 0);
        do_access(0, 1, 3'd1, 32'h202, 32'h00001234, 0, 0, 0);
        do_access(0, 1, 3'd2, 32'h204, 32'hCAFEF00D, 0, 2, 1);
    endtask

    task automatic test_hold();
        do_access(1, 0, 3'd2, 32'h300, 0, 32'h0BADF00D, 0, 3);
        do_access(1, 0, 3'd1, 32'h306, 0, 32'h9ABC0000, 2, 2);
    endtask

    task automatic test_misaligned();
        do_access(1, 0, 3'd2, 32'h102, 0, 0, 0, 0);
        do_access(0, 1, 3'd1, 32'h203, 32'h55, 0, 0, 0);
        do_access(0, 0, 3'd2, 32'h101, 0, 0, 0, 0);
    endtask

    task automatic test_reset_busy();
        valid_i = 1; mem_read_i = 1; funct3_i = 3'd2; alu_out_i = 32'h400;
        advance_i = 0; dmem_resp = 0;
        step(); step();
        rst = 1;
        step();
        rst = 0; idle_inputs(); dmem_resp = 1; dmem_rdata = 32'hFFFFFFFF;
        exp_cnt = 0;
        @(negedge clk);
        checks++;
        if (dmem_read !== 0 || stall_o !== 0 || mem_data_out_o !== 0 || mem_stall_cycles_o !== 0) begin
            errors++;
            $display("FAIL reset_busy: rd=%b stall=%b data=%h cnt=%0d want 0 0 0 0",
                     dmem_read, stall_o, mem_data_out_o, mem_stall_cycles_o);
        end
        step();
        idle_inputs();
        do_access(1, 0, 3'd2, 32'h404, 0, 32'h13572468, 1, 0);
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};
        for (int i = 0; i < 120; i++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if (kind < 5)
                do_access(1, 0, ld_f3[$urandom_range(0, 4)], a, 0, $urandom,
                          $urandom_range(0, 4), $urandom_range(0, 2));
            else if (kind < 9)
                do_access(0, 1, st_f3[$urandom_range(0, 2)], a, $urandom, 0,
                          $urandom_range(0, 4), $urandom_range(0, 2));
            else
                do_access(0, 0, 3'(a), a, 0, 0, 0, 0);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_directed_loads();
        test_directed_stores();
        test_hold();
        test_misaligned();
        test_reset_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
